// File: rtl/cpu_pkg.sv
// Shared CPU constants: instruction/address widths and the NOP encoding
// used by the PC, instruction memory and fetch queue.
package cpu_pkg;

   localparam int INSTR_W = 16;
   localparam int IADDR_W = 10;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

endpackage : cpu_pkg

// File: rtl/fetch_queue.sv
// Fetch queue: circular buffer of {instr, addr} between instruction fetch
// and decode. Provides first-word-fall-through head output, a PC stall hint
// that leaves two entries of skid, a sticky overflow flag, and flush with a
// one-cycle squash of the wrong-path word still in flight from memory.
module fetch_queue #(
   parameter int DEPTH   = 4,
   parameter int INSTR_W = cpu_pkg::INSTR_W,
   parameter int IADDR_W = cpu_pkg::IADDR_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     fetch_valid,
   input  logic [INSTR_W-1:0]       instr_in,
   input  logic [IADDR_W-1:0]       addr_in,
   input  logic                     flush,
   input  logic                     dec_ready,
   output logic                     instr_valid,
   output logic [INSTR_W-1:0]       instr_out,
   output logic [IADDR_W-1:0]       pc_out,
   output logic                     stall,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - 2);

   logic [INSTR_W-1:0] instr_mem_q [DEPTH];
   logic [IADDR_W-1:0] addr_mem_q  [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          squash_q, squash_d;
   logic          overflow_q, overflow_d;

   logic pop;
   logic push;
   logic accept;

   // Next-state for pointers, occupancy, squash and overflow.
   always_comb begin
      pop        = instr_valid & dec_ready & ~flush;
      push       = fetch_valid & ~flush & ~squash_q;
      // A full queue still accepts when the head leaves in the same cycle.
      accept     = push & ((count_q != FULL_CNT) | pop);

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      squash_d   = 1'b0;
      overflow_d = overflow_q | (push & ~accept);

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         squash_d = 1'b1;
      end else begin
         if (accept) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)    rd_ptr_d = rd_ptr_q + PW'(1);
         case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         squash_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         squash_q   <= squash_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage write; contents are left unreset and masked by occupancy.
   always_ff @(posedge clk) begin
      if (accept) begin
         instr_mem_q[wr_ptr_q] <= instr_in;
         addr_mem_q[wr_ptr_q]  <= addr_in;
      end
   end

   // Head outputs from registered pointer/count only.
   always_comb begin
      instr_valid = (count_q != '0);
      instr_out   = INSTR_W'(cpu_pkg::NOP_INSTR);
      pc_out      = '0;
      if (instr_valid) begin
         instr_out = instr_mem_q[rd_ptr_q];
         pc_out    = addr_mem_q[rd_ptr_q];
      end
   end

   assign stall    = (count_q >= STALL_CNT);
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH = 4).
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_valid;
   logic [15:0] instr_in;
   logic [9:0]  addr_in;
   logic        flush;
   logic        dec_ready;
   logic        instr_valid;
   logic [15:0] instr_out;
   logic [9:0]  pc_out;
   logic        stall;
   logic [2:0]  count;
   logic        overflow;

   int unsigned errors = 0;
   int unsigned checks = 0;

   fetch_queue #(.DEPTH(4), .INSTR_W(16), .IADDR_W(10)) dut (
      .clk         (clk),
      .reset       (reset),
      .fetch_valid (fetch_valid),
      .instr_in    (instr_in),
      .addr_in     (addr_in),
      .flush       (flush),
      .dec_ready   (dec_ready),
      .instr_valid (instr_valid),
      .instr_out   (instr_out),
      .pc_out      (pc_out),
      .stall       (stall),
      .count       (count),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_head(input string tag, input logic v, input logic [15:0] ins,
                             input logic [9:0] pc, input logic [2:0] cnt);
      check({tag, ".valid"}, 32'(instr_valid), 32'(v));
      check({tag, ".instr"}, 32'(instr_out), 32'(ins));
      check({tag, ".pc"},    32'(pc_out), 32'(pc));
      check({tag, ".count"}, 32'(count), 32'(cnt));
   endtask

   initial begin
      logic [3:0] fill_stall;
      fill_stall = 4'b1110;  // stall expected after pushes 1..4 (bit i = after push i+1)

      reset = 1'b1; fetch_valid = 1'b0; instr_in = '0; addr_in = '0;
      flush = 1'b0; dec_ready = 1'b0;
      #12;
      check_head("reset", 1'b0, 16'h0000, 10'd0, 3'd0);
      check("reset.stall", 32'(stall), 32'd0);
      check("reset.ovf", 32'(overflow), 32'd0);
      tick();
      reset = 1'b0;

      // Fill with decode stalled
      for (int i = 0; i < 4; i++) begin
         fetch_valid = 1'b1; instr_in = 16'h0011 + 16'(i); addr_in = 10'(i);
         tick();
         check("fill.count", 32'(count), 32'(i + 1));
         check("fill.stall", 32'(stall), 32'(fill_stall[i]));
         check("fill.ovf", 32'(overflow), 32'd0);
         check("fill.head", 32'(instr_out), 32'h0011);
      end

      // Push into the full queue: dropped, sticky overflow
      instr_in = 16'h00FF; addr_in = 10'h3FF;
      tick();
      fetch_valid = 1'b0;
      check_head("ovf", 1'b1, 16'h0011, 10'd0, 3'd4);
      check("ovf.flag", 32'(overflow), 32'd1);

      // Drain in order
      dec_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_head("drain", 1'b1, 16'h0011 + 16'(i), 10'(i), 3'(4 - i));
         tick();
      end
      check_head("drained", 1'b0, 16'h0000, 10'd0, 3'd0);
      check("drained.stall", 32'(stall), 32'd0);
      check("drained.ovf", 32'(overflow), 32'd1);

      // Push and pop requested while empty: push wins, nothing popped
      fetch_valid = 1'b1; instr_in = 16'h0030; addr_in = 10'h010;
      tick();
      check_head("emptypp", 1'b1, 16'h0030, 10'h010, 3'd1);

      // Queue three entries
      dec_ready = 1'b0;
      instr_in = 16'h0031; addr_in = 10'h011; tick();
      instr_in = 16'h0032; addr_in = 10'h012; tick();
      check("q3.count", 32'(count), 32'd3);

      // Flush with a wrong-path word, then the in-flight wrong-path word
      flush = 1'b1; dec_ready = 1'b1; instr_in = 16'hBAD0; addr_in = 10'h0BD;
      tick();
      flush = 1'b0; dec_ready = 1'b0;
      check_head("flush", 1'b0, 16'h0000, 10'd0, 3'd0);
      instr_in = 16'hBAD1; addr_in = 10'h0BE;
      tick();
      check_head("squash", 1'b0, 16'h0000, 10'd0, 3'd0);
      instr_in = 16'h0020; addr_in = 10'h020;
      tick();
      check_head("postflush", 1'b1, 16'h0020, 10'h020, 3'd1);

      // Continuous push+pop across pointer wrap
      dec_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         instr_in = 16'h0040 + 16'(i); addr_in = 10'h040 + 10'(i);
         tick();
         check_head("wrap", 1'b1, 16'h0040 + 16'(i), 10'h040 + 10'(i), 3'd1);
      end

      // Two entries queued, then asynchronous reset between edges
      dec_ready = 1'b0;
      instr_in = 16'h0055; addr_in = 10'h055;
      tick();
      fetch_valid = 1'b0;
      check("prerst.count", 32'(count), 32'd2);
      #3 reset = 1'b1;
      #1;
      check_head("asyncrst", 1'b0, 16'h0000, 10'd0, 3'd0);
      check("asyncrst.ovf", 32'(overflow), 32'd0);
      check("asyncrst.stall", 32'(stall), 32'd0);
      #2 reset = 1'b0;
      dec_ready = 1'b1;
      tick();
      check_head("postrst", 1'b0, 16'h0000, 10'd0, 3'd0);
      dec_ready = 1'b0;
      fetch_valid = 1'b1; instr_in = 16'h0066; addr_in = 10'h005;
      tick();
      fetch_valid = 1'b0;
      check_head("postrst.push", 1'b1, 16'h0066, 10'h005, 3'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_fetch_queue
